// File: rtl/seg7_disp_scheduler_pkg.sv
// Shared definitions for the 7-segment display scheduler and its driver.
//   - op-code and display-mode constants understood by Seg7_Driver
//   - scheduler FSM state encoding
//   - latched display payload (mode/op/digit) as one packed bus
package seg7_pkg;

  localparam logic [2:0] OP_T = 3'd0;
  localparam logic [2:0] OP_A = 3'd1;
  localparam logic [2:0] OP_C = 3'd2;
  localparam logic [2:0] OP_B = 3'd3;

  localparam logic MODE_OP    = 1'b0;
  localparam logic MODE_DIGIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic       mode;
    logic [2:0] op;
    logic [3:0] digit;
  } disp_payload_t;

endpackage

// File: rtl/seg7_disp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after `last`
// (wrapping modulo NUM_REQ) whose request is set.
// Ports:
//   req_valid    - per-requester request vector
//   last         - index of the previous winner
//   win_onehot_c - one-hot winner (all zero when no request)
//   win_idx_c    - winner index
//   win_any_c    - at least one request present
module seg7_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win_onehot_c,
  output logic [IDX_W-1:0]   win_idx_c,
  output logic               win_any_c
);

  int best_c;
  int dist_c;

  // Distance from `last` is 1..NUM_REQ; the smallest requesting distance wins.
  always_comb begin
    win_idx_c = '0;
    win_any_c = 1'b0;
    best_c    = int'(NUM_REQ) + 1;
    dist_c    = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      dist_c = (i > int'(last)) ? (i - int'(last)) : (i + int'(NUM_REQ) - int'(last));
      if (req_valid[i] && (dist_c < best_c)) begin
        best_c    = dist_c;
        win_idx_c = IDX_W'(i);
        win_any_c = 1'b1;
      end
    end
  end

  always_comb begin
    win_onehot_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      win_onehot_c[i] = win_any_c && (win_idx_c == IDX_W'(i));
    end
  end

endmodule

// File: rtl/seg7_disp_scheduler.sv
// Time-shares the single Seg7_Driver between NUM_REQ requesters: round-robin
// grant, latch the winner's payload, show it HOLD_CYCLES, blank GAP_CYCLES.
// Optional build macro SEG7_SCHED_BLINK_EN: o_en blinks with half-period
// BLINK_CYCLES during SHOW (SHOW length unchanged).
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   req_valid/mode/op/digit  - per-requester request and packed payload
//   abort                    - cancel the current display
//   req_ready                - one-cycle one-hot acceptance pulse
//   grant, busy              - owner / activity during SHOW and GAP
//   o_en, o_disp_mode, o_op_code, o_digit_val - driver inputs
module seg7_disp_scheduler
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned GAP_CYCLES   = 5_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_mode,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [4*NUM_REQ-1:0] req_digit,
  input  logic                 abort,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 o_en,
  output logic                 o_disp_mode,
  output logic [2:0]           o_op_code,
  output logic [3:0]           o_digit_val
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LOAD = (BLINK_CYCLES == 0) ? '0 : CNT_W'(BLINK_CYCLES - 1);

`ifdef SEG7_SCHED_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  sched_state_t        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                en_q, en_d;
  disp_payload_t       pay_q, pay_d;

  logic [NUM_REQ-1:0]  win_onehot_c;
  logic [IDX_W-1:0]    win_idx_c;
  logic                win_any_c;
  disp_payload_t       req_pay_c;

  seg7_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid    (req_valid),
    .last         (last_q),
    .win_onehot_c (win_onehot_c),
    .win_idx_c    (win_idx_c),
    .win_any_c    (win_any_c)
  );

  // Select the winner's live payload for latching.
  always_comb begin
    req_pay_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_onehot_c[i]) begin
        req_pay_c = '{mode: req_mode[i], op: req_op[3*i +: 3], digit: req_digit[4*i +: 4]};
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blink_cnt_d = blink_cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    ready_d     = '0;
    busy_d      = busy_q;
    en_d        = en_q;
    pay_d       = pay_q;

    unique case (state_q)
      IDLE: begin
        if (!abort && win_any_c) begin
          state_d     = SHOW;
          cnt_d       = HOLD_LOAD;
          blink_cnt_d = BLINK_LOAD;
          last_d      = win_idx_c;
          grant_d     = win_onehot_c;
          ready_d     = win_onehot_c;
          busy_d      = 1'b1;
          en_d        = 1'b1;
          pay_d       = req_pay_c;
        end
      end
      SHOW: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          en_d    = 1'b0;
        end else if (cnt_q == '0) begin
          en_d        = 1'b0;
          blink_cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (BLINK_EN) begin
            if (blink_cnt_q == '0) begin
              en_d        = !en_q;
              blink_cnt_d = BLINK_LOAD;
            end else begin
              blink_cnt_d = blink_cnt_q - CNT_W'(1);
            end
          end
        end
      end
      GAP: begin
        if (abort || (cnt_q == '0)) begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
          busy_d  = 1'b0;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      blink_cnt_q <= '0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      grant_q     <= '0;
      ready_q     <= '0;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      pay_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      pay_q       <= pay_d;
    end
  end

  assign req_ready   = ready_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign o_en        = en_q;
  assign o_disp_mode = pay_q.mode;
  assign o_op_code   = pay_q.op;
  assign o_digit_val = pay_q.digit;

endmodule

// File: tb/tb_seg7_disp_scheduler.sv
// Scoreboard bench for seg7_disp_scheduler (NUM_REQ=3, HOLD=8, GAP=2, BLINK=2).
module tb_seg7_disp_scheduler;
  import seg7_pkg::*;

  localparam int N = 3;
  localparam int H = 8;
  localparam int G = 2;
  localparam int B = 2;
`ifdef SEG7_SCHED_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_mode;
  logic [3*N-1:0] req_op;
  logic [4*N-1:0] req_digit;
  logic           abort;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           o_en;
  logic           o_disp_mode;
  logic [2:0]     o_op_code;
  logic [3:0]     o_digit_val;

  seg7_disp_scheduler #(
    .NUM_REQ      (N),
    .HOLD_CYCLES  (H),
    .GAP_CYCLES   (G),
    .BLINK_CYCLES (B),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_op      (req_op),
    .req_digit   (req_digit),
    .abort       (abort),
    .req_ready   (req_ready),
    .grant       (grant),
    .busy        (busy),
    .o_en        (o_en),
    .o_disp_mode (o_disp_mode),
    .o_op_code   (o_op_code),
    .o_digit_val (o_digit_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       mode;
    logic [2:0] op;
    logic [3:0] dig;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic       mode_a[N];
  logic [2:0] op_a[N];
  logic [3:0] dig_a[N];
  int         mlast;
  int         next_dig = -1;
  logic       abort_s = 1'b0;
  logic [N-1:0] valid_s = '0;

  // What the DUT saw at the most recent edge.
  always @(posedge clk) begin
    abort_s <= abort;
    valid_s <= req_valid;
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  function automatic logic [N-1:0] onehot(int idx);
    return N'(1) << idx;
  endfunction

  // o_en for the p-th SHOW cycle (p starts at 1).
  function automatic logic show_en(int p);
    return !BLINK_ON || ((((p - 1) / B) % 2) == 0);
  endfunction

  // Monitor: follows each display window from its req_ready pulse.
  initial begin : monitor
    int   phase;
    bit   prev_idle;
    bit   idle_now;
    exp_t cur;
    phase     = 0;
    prev_idle = 1'b1;
    cur       = '{idx: 0, mode: 1'b0, op: 3'd0, dig: 4'd0};
    forever begin
      @(negedge clk);
      idle_now = 1'b0;
      if (!rst_n) begin
        phase    = 0;
        idle_now = 1'b1;
      end else if (phase != 0) begin
        if (abort_s || (phase == H + G)) begin
          chk("window_end_idle", 32'({req_ready, grant, busy, o_en}), 32'd0);
          phase    = 0;
          idle_now = 1'b1;
        end else begin
          phase++;
          chk("grant_held", 32'(grant), 32'(onehot(cur.idx)));
          chk("busy_high", 32'(busy), 32'd1);
          chk("ready_pulse_once", 32'(req_ready), 32'd0);
          chk("payload_held", 32'({o_disp_mode, o_op_code, o_digit_val}),
              32'({cur.mode, cur.op, cur.dig}));
          if (phase <= H) chk("o_en_show", 32'(o_en), 32'(show_en(phase)));
          else            chk("o_en_gap", 32'(o_en), 32'd0);
        end
      end else begin
        chk("grant_timing", 32'(req_ready != '0), 32'(prev_idle && (valid_s != '0) && !abort_s));
        if (req_ready != '0) begin
          if (sb.size() == 0) fail_now("unexpected_grant");
          else                cur = sb.pop_front();
          chk("winner", 32'(req_ready), 32'(onehot(cur.idx)));
          chk("grant_start", 32'(grant), 32'(onehot(cur.idx)));
          chk("busy_en_start", 32'({busy, o_en}), 32'({1'b1, show_en(1)}));
          chk("payload_latched", 32'({o_disp_mode, o_op_code, o_digit_val}),
              32'({cur.mode, cur.op, cur.dig}));
          phase = 1;
        end else begin
          chk("idle_outputs", 32'({grant, busy, o_en}), 32'd0);
          idle_now = 1'b1;
        end
      end
      prev_idle = idle_now;
    end
  end

  task automatic drive_payload();
    for (int i = 0; i < N; i++) begin
      req_mode[i]        = mode_a[i];
      req_op[3*i +: 3]    = op_a[i];
      req_digit[4*i +: 4] = dig_a[i];
    end
  endtask

  task automatic rand_payload(input int i);
    mode_a[i] = 1'($urandom_range(1));
    op_a[i]   = 3'($urandom_range(7));
    dig_a[i]  = 4'($urandom_range(15));
  endtask

  // One cycle; an accepted requester drops valid and scrambles its live payload.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        req_valid[i] = 1'b0;
        rand_payload(i);
        if (next_dig >= 0) begin
          dig_a[i] = 4'(next_dig);
          next_dig = -1;
        end
      end
    end
    drive_payload();
  endtask

  // Raise requesters in s together; expected grant order is plain round-robin.
  task automatic run_round(input logic [N-1:0] s, input int abort_at);
    logic [N-1:0] rem;
    int p;
    int budget;
    rem = s;
    while (rem != '0) begin
      p = 0;
      for (int k = 1; k <= N; k++) begin
        p = (mlast + k) % N;
        if (rem[p]) break;
      end
      sb.push_back('{idx: p, mode: mode_a[p], op: op_a[p], dig: dig_a[p]});
      rem[p] = 1'b0;
      mlast  = p;
    end
    drive_payload();
    req_valid = req_valid | s;
    if (abort_at > 0) begin
      budget = 0;
      while ((req_ready == '0) && (budget < 40)) begin
        tick();
        budget++;
      end
      if (budget >= 40) fail_now("abort_wait_timeout");
      repeat (abort_at - 1) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    budget = 0;
    while (((req_valid != '0) || (sb.size() != 0) || busy) && (budget < 200)) begin
      tick();
      budget++;
    end
    if (budget >= 200) fail_now("round_timeout");
    tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int budget;
    rst_n     = 1'b1;
    req_valid = '0;
    abort     = 1'b0;
    for (int i = 0; i < N; i++) rand_payload(i);
    drive_payload();
    mlast = N - 1;
    #3 rst_n = 1'b0;
    #1 chk("reset_outputs", 32'({req_ready, grant, busy, o_en, o_disp_mode, o_op_code, o_digit_val}), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request: op symbol A.
    mode_a[0] = MODE_OP;
    op_a[0]   = OP_A;
    run_round(3'b001, 0);

    // All three at once.
    run_round(3'b111, 0);

    // Digit 13 latched; live digit becomes 4 during SHOW.
    mode_a[1] = MODE_DIGIT;
    dig_a[1]  = 4'd13;
    next_dig  = 4;
    run_round(3'b010, 0);

    // Abort at SHOW cycle 3 of req1 with req2 pending.
    run_round(3'b001, 0);
    run_round(3'b110, 3);

    // Asynchronous reset mid-SHOW.
    sb.push_back('{idx: 2, mode: mode_a[2], op: op_a[2], dig: dig_a[2]});
    req_valid[2] = 1'b1;
    budget = 0;
    while ((req_ready == '0) && (budget < 40)) begin
      tick();
      budget++;
    end
    if (budget >= 40) fail_now("reset_test_grant_timeout");
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_show",
           32'({req_ready, grant, busy, o_en, o_disp_mode, o_op_code, o_digit_val}), 32'd0);
    req_valid = '0;
    sb.delete();
    mlast = N - 1;
    tick();
    rst_n = 1'b1;
    tick();
    run_round(3'b011, 0);

    // Randomized rounds with occasional aborts.
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] s;
      int ab;
      for (int i = 0; i < N; i++) rand_payload(i);
      s  = N'($urandom_range(1, 7));
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(1, H + G + 1)) : 0;
      run_round(s, ab);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_disp_scheduler.md
# seg7_disp_scheduler

Time-shares the single 7-segment driver (`Seg7_Driver`) between several display requesters, such as the operation selector, result path and error handler. It arbitrates round-robin, latches the winner's payload and drives it for a fixed hold time. It then blanks for a fixed gap before serving the next request. The block sits directly upstream of the driver and owns its `i_en`, `i_disp_mode`, `i_op_code` and `i_digit_val` inputs.

## Interface
- `NUM_REQ`, 3: number of requesters, legal range 1..8.
- `HOLD_CYCLES`, 50_000_000: SHOW duration in clk cycles, ≥1.
- `GAP_CYCLES`, 5_000_000: blank duration after SHOW; 0 skips GAP.
- `BLINK_CYCLES`, 12_500_000: half-period of blink; used only with the macro.
- `CNT_W`, 32: width of the hold/gap down-counter.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, NUM_REQ: per-requester request, level, held until `req_ready`.
- `req_mode`, in, NUM_REQ: 0 = op symbol, 1 = digit.
- `req_op`, in, 3*NUM_REQ: packed op codes, requester i at [3i+2:3i].
- `req_digit`, in, 4*NUM_REQ: packed digit values 0..15, requester i at [4i+3:4i].
- `abort`, in, 1: synchronous cancel of the current display.
- `req_ready`, out, NUM_REQ: one-cycle one-hot acceptance pulse.
- `grant`, out, NUM_REQ: one-hot owner during SHOW and GAP.
- `busy`, out, 1: high in SHOW and GAP.
- `o_en`, out, 1: to driver `i_en`.
- `o_disp_mode`, out, 1: to driver `i_disp_mode`.
- `o_op_code`, out, 3: to driver `i_op_code`.
- `o_digit_val`, out, 4: to driver `i_digit_val`.

## Operation
- The FSM has three states: IDLE, SHOW and GAP.
- **Reset values:** all outputs 0, state IDLE, counter 0, round-robin pointer `last` = NUM_REQ-1 so requester 0 wins first.
- **IDLE:**
  - If `abort`=0 and `req_valid`≠0, choose the first set bit searching `last`+1, `last`+2, … modulo NUM_REQ.
  - On that edge: latch its mode/op/digit, set `grant` and `last` to the winner, pulse its `req_ready`, load counter with HOLD_CYCLES-1, go to SHOW.
- **SHOW:**
  - `o_en`=1 and the payload outputs hold the latched values; live inputs are ignored.
  - The counter decrements each cycle.
  - At counter 0: go to GAP with counter loaded GAP_CYCLES-1, or go to IDLE when GAP_CYCLES=0.
- **GAP:**
  - `o_en`=0, payload outputs hold their values and `grant` is held.
  - At counter 0: go to IDLE and clear `grant`.
- **abort:**
  - Sampled in SHOW or GAP: next state is IDLE, `o_en`, `grant` and `busy` are cleared, and `last` is kept.
  - Sampled in IDLE: no grant that cycle, even if `req_valid` is set.
- **Requester protocol:**
  - Dropping `req_valid` before `req_ready` is a withdrawal and has no effect.
  - `req_valid` must drop in the cycle after `req_ready`. If it stays high, it is treated as a new request at the next IDLE.
- **Payload:** digits 10..15 and op codes ≥4 pass through unchanged; the driver renders them as "1x" and "E" respectively.
- **Single requester:** with NUM_REQ=1 the same requester is re-granted every time.

## Timing
- All outputs are registered.
- `req_valid` high in IDLE at edge k: `req_ready`, `grant`, `busy` and `o_en` go high after edge k.
- `o_en` stays high for exactly HOLD_CYCLES cycles, followed by exactly GAP_CYCLES low cycles in GAP.
- IDLE occupies at least one cycle between grants. Back-to-back period = HOLD_CYCLES + GAP_CYCLES + 1.
- Asynchronous reset mid-SHOW clears all outputs immediately, without waiting for a clock edge.

## Configuration
- `SEG7_SCHED_BLINK_EN` defined: during SHOW, `o_en` starts at 1 and toggles every BLINK_CYCLES cycles via a separate blink counter reset at SHOW entry. SHOW length is unchanged.
- Not defined: `o_en` is steady 1 throughout SHOW, and BLINK_CYCLES is unused.

## Structure
- Package `seg7_pkg` holds:
  - op-code constants OP_T=0, OP_A=1, OP_C=2, OP_B=3;
  - mode constants MODE_OP=0, MODE_DIGIT=1;
  - FSM state enum `sched_state_t`.
- Sub-module `seg7_rr_arbiter` is combinational. It takes `req_valid` and `last` and returns a one-hot winner plus an index.

## Test plan
All scenarios use NUM_REQ=3, HOLD_CYCLES=8, GAP_CYCLES=2 and BLINK_CYCLES=2.
- **Single request:** req0 with mode=0, op=1 → `req_ready[0]` 1 cycle; `o_en`=1 for 8 cycles with `o_op_code`=1; 2 blank cycles; `busy` 0 after 10 cycles.
- **Round-robin:** req0, req1 and req2 held continuously → grants in order 0, 1, 2, 0; each start is 11 cycles apart.
- **Digit payload:** req1 with mode=1, digit=13; `req_digit` changed to 4 during SHOW → `o_digit_val` stays 13 for all 8 cycles.
- **Abort:** abort at SHOW cycle 3 → `o_en`, `grant` and `busy` are 0 next cycle; a pending req2 is granted on the following IDLE cycle.
- **Reset mid-SHOW:** `rst_n` low mid-SHOW → all outputs 0 asynchronously; after release, req1 and req0 pending → req0 is granted first.
- **Blink (macro on):** `o_en` pattern over SHOW is 1,1,0,0,1,1,0,0.
